// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Request/response bundle for one requester of the shared RAM.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Fixed-priority arbiter (D > F > X) with starvation promotion that
//            shares one single-port synchronous RAM and returns read data.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave d,
    mem_port_arbiter_if.slave f,
    mem_port_arbiter_if.slave x,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic              busy
);
    localparam int c_cnt_w  = $clog2(STARVE_MAX + 1);
    localparam int c_wait_w = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_cnt_w-1:0]  c_starve_max = c_cnt_w'(STARVE_MAX);
    localparam logic [c_wait_w-1:0] c_wait_last  = c_wait_w'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          w_req;
    logic [2:0]          w_we;
    logic [2:0]          w_prom;
    logic [2:0]          w_gnt;
    logic [2:0]          w_rvalid;
    logic [2:0]          r_owner;
    logic [1:0]          w_idx;
    logic                w_grant_ok;
    logic                w_capture;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_cnt_w-1:0]  r_starve [3];
    logic [DW-1:0]       r_rdata  [3];
    logic                w_unused_f;

    // Index 0 = D, 1 = F, 2 = X; F is read-only so its write fields are ignored.
    assign w_req      = {x.req, f.req, d.req};
    assign w_we       = {x.we, 1'b0, d.we};
    assign w_unused_f = ^{f.we, f.wdata};

    // Grants only from IDLE and never while reset is held.
    assign w_grant_ok = (r_state == S_IDLE) && !rst && (|w_req);
    assign busy       = (r_state != S_IDLE);

    for (genvar i = 0; i < 3; i++) begin : g_prom
        assign w_prom[i] = w_req[i] && (r_starve[i] == c_starve_max);
    end

    // Promoted requesters pre-empt the normal order; both use D > F > X.
    always_comb begin
        w_idx = 2'd2;
        if (|w_prom) begin
            if (w_prom[0])      w_idx = 2'd0;
            else if (w_prom[1]) w_idx = 2'd1;
        end else begin
            if (w_req[0])       w_idx = 2'd0;
            else if (w_req[1])  w_idx = 2'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt        = 3'b000;
        w_rvalid     = 3'b000;
        w_capture    = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ok) begin
                    w_gnt  = 3'b001 << w_idx;
                    ram_en = 1'b1;
                    ram_we = w_we[w_idx];
                    case (w_idx)
                        2'd0: begin
                            ram_addr  = d.addr;
                            ram_wdata = d.wdata;
                        end
                        2'd1: begin
                            ram_addr  = f.addr;
                            ram_wdata = '0;
                        end
                        default: begin
                            ram_addr  = x.addr;
                            ram_wdata = x.wdata;
                        end
                    endcase
                    if (!ram_we) w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_rvalid     = r_owner;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 3'b000;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                r_wait_cnt <= '0;
                if (w_state_next == S_WAIT) r_owner <= w_gnt;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_rdata[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < 3; i++) begin
                if (r_owner[i]) r_rdata[i] <= ram_rdata;
            end
        end
    end

    // Losses only accumulate on IDLE grant cycles; a low req clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_starve[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!w_req[i] || w_gnt[i]) begin
                    r_starve[i] <= '0;
                end else if (w_grant_ok && (r_starve[i] != c_starve_max)) begin
                    r_starve[i] <= r_starve[i] + 1'b1;
                end
            end
        end
    end

    assign d.gnt    = w_gnt[0];
    assign d.rvalid = w_rvalid[0];
    assign d.rdata  = r_rdata[0];
    assign f.gnt    = w_gnt[1];
    assign f.rvalid = w_rvalid[1];
    assign f.rdata  = r_rdata[1];
    assign x.gnt    = w_gnt[2];
    assign x.rvalid = w_rvalid[2];
    assign x.rdata  = r_rdata[2];

endmodule
`default_nettype wire
